ask_tx_scheduler: RTL and testbench
===================================

Name: ask_tx_scheduler

Overview:
Frame scheduler and arbiter for the on-chip ASK transmitter. It accepts byte requests from up to 4 requesters using valid/ready and grants them round-robin. For each granted byte it sequences a frame onto the shared modulator: preamble bits, then 8 data bits MSB first, then guard zeros. It owns the carrier and bit-rate dividers and drives carrier, message and the gated ask_mod output.

Parameters:
CAR_DIV, 6000, carrier half-period in clk cycles (48 MHz / 6000 / 2 = 4 kHz carrier); legal range ≥1
BIT_DIV, 48000, clk cycles per transmitted bit (1 kbit/s); legal range ≥2
N_REQ, 4, number of requesters; legal range 1..4
PRE_BITS, 4, preamble length in bits; pattern alternates 1,0,1,0… starting with 1
GUARD_BITS, 2, trailing zero bits after data; legal range ≥1

Ports:
clk  in  1  system clock (48 MHz HFOSC domain)
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits new grants; does not abort a frame in progress
req_valid  in  N_REQ  per-requester byte-valid
req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  N_REQ  one-cycle pulse; byte accepted from requester i
busy  out  1  high while a frame is in progress
grant_id  out  2  index of the requester whose frame is current or last sent
carrier  out  1  free-running square-wave carrier
message  out  1  current frame bit (baseband)
ask_mod  out  1  registered carrier & message

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): all outputs 0. State IDLE. Counters 0. Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- Carrier divider: free-running from reset, independent of enable and state.
  - car_ctr counts 0..CAR_DIV-1.
  - carrier toggles on the cycle car_ctr == CAR_DIV-1; car_ctr wraps to 0 on that cycle.
  - Carrier period = 2*CAR_DIV cycles.
- ask_mod is registered from the current carrier and message values (1-cycle latency).
- State machine: IDLE → PRE → DATA → GUARD → IDLE.
- IDLE:
  - message = 0, busy = 0.
  - If enable = 1 and any req_valid is high, grant the first valid requester after the pointer, searching upward with modulo-N_REQ wrap.
  - On the grant cycle: req_ready[g] = 1 for exactly that cycle; req_data[g] is latched into a shift register; grant_id = g; pointer = g.
  - Next cycle: state = PRE, busy = 1, message = 1 (preamble bit 0), bit_ctr = 0.
- Bit timing:
  - In PRE, DATA and GUARD, bit_ctr counts 0..BIT_DIV-1.
  - A bit_tick occurs when bit_ctr == BIT_DIV-1; bit_ctr wraps to 0 on that cycle.
  - message changes only on the cycle after a bit_tick, so each bit is held exactly BIT_DIV cycles.
- PRE: send PRE_BITS bits. Bit k = 1 when k is even, 0 when k is odd. After the last preamble bit_tick → DATA, message = latched bit 7.
- DATA: send 8 bits, MSB first (bit 7 down to bit 0). After the 8th bit_tick → GUARD, message = 0.
- GUARD: hold message = 0 for GUARD_BITS bit periods. After the last bit_tick → IDLE, busy = 0.
- The earliest next grant is on the first IDLE cycle. The gap between frames is therefore 1 cycle minimum.
- Frame duration: busy is high for exactly (PRE_BITS+8+GUARD_BITS)*BIT_DIV cycles.
- enable deasserted mid-frame: the frame completes normally; no new grant is issued while enable = 0.
- Changes to req_valid or req_data after the grant have no effect on the current frame.
- A requester that drops valid before being granted is skipped; no ready pulse is issued to it.
- All requesters valid continuously: grants rotate 0,1,2,3,0,…
- A single requester valid continuously: it is granted for every frame.
- Requester indices ≥ N_REQ do not exist; grant_id stays < N_REQ.

Test Plan:
- Bench settings for all scenarios: CAR_DIV=2, BIT_DIV=8, PRE_BITS=4, GUARD_BITS=2.
- Reset, then idle 40 cycles with no valid → carrier toggles every 2 cycles; message, ask_mod, busy and req_ready stay 0.
- enable=1, req_valid=0001, data0=8'hAC:
  - req_ready=0001 for 1 cycle; busy high for 112 cycles.
  - message sequence in 8-cycle bits = 1,0,1,0, 1,0,1,0,1,1,0,0, 0,0.
  - ask_mod == previous-cycle carrier & message on every cycle.
- req_valid=1111 held, data i = 8'h10+i, 5 frames → grant_id 0,1,2,3,0; each req_ready pulses once per grant; 1 idle cycle between frames.
- Frame to requester 2 in progress; drop enable at cycle 30 of the frame → frame completes all 112 cycles; no further grant while enable=0. Re-raise enable → requester 3 is granted next.
- Assert rst_n=0 mid-DATA, 3 cycles → outputs 0 immediately. After release: IDLE; the next grant goes to requester 0 even though requester 2 was the last grant.
- req_valid=0100 asserted, then data2 changed to 8'hFF on the cycle after req_ready → the transmitted data bits match the value present on the ready cycle.

Source files
------------

// File: rtl/ask_tx_scheduler.sv
// Round-robin byte arbiter and ASK frame sequencer: preamble, 8 data bits MSB first,
// guard zeros; also owns the free-running carrier divider and the gated ask_mod output.
module ask_tx_scheduler #(
   parameter int CAR_DIV    = 6000,
   parameter int BIT_DIV    = 48000,
   parameter int N_REQ      = 4,
   parameter int PRE_BITS   = 4,
   parameter int GUARD_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 busy,
   output logic [1:0]           grant_id,
   output logic                 carrier,
   output logic                 message,
   output logic                 ask_mod
);

   // state   | meaning
   // S_IDLE  | no frame; grant the next valid requester when enabled
   // S_PRE   | sending the 1,0,1,0... preamble
   // S_DATA  | sending the latched byte, MSB first
   // S_GUARD | sending trailing zero bits
   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GUARD} state_t;

   localparam int CW   = (CAR_DIV > 1) ? $clog2(CAR_DIV) : 1;
   localparam int BW   = $clog2(BIT_DIV);
   localparam int MAXB = (PRE_BITS > 8) ? ((PRE_BITS > GUARD_BITS) ? PRE_BITS : GUARD_BITS)
                                        : ((GUARD_BITS > 8) ? GUARD_BITS : 8);
   localparam int IW   = $clog2(MAXB);

   localparam logic [CW-1:0] CAR_LAST  = CW'(CAR_DIV - 1);
   localparam logic [CW-1:0] CAR_ONE   = CW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] PRE_LAST  = IW'(PRE_BITS - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(7);
   localparam logic [IW-1:0] GRD_LAST  = IW'(GUARD_BITS - 1);
   localparam logic [1:0]    REQ_LAST  = 2'(N_REQ - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   car_ctr_q;
   logic            carrier_q;
   logic            ask_mod_q;
   logic [BW-1:0]   bit_ctr_q, bit_ctr_d;
   logic [IW-1:0]   bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            message_q, message_d;
   logic            busy_q, busy_d;
   logic [1:0]      grant_id_q, grant_id_d;
   logic [1:0]      ptr_q, ptr_d;

   logic [3:0]      valid_ext;
   logic [3:0]      ready_ext;
   logic [7:0]      req_byte [4];
   logic            grant_found;
   logic [1:0]      grant_idx;
   logic [1:0]      search_idx;
   logic            grant_go;
   logic            car_tc;
   logic            bit_tick;

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      if (gi < N_REQ) begin : g_real
         assign req_byte[gi] = req_data[8*gi +: 8];
      end else begin : g_absent
         assign req_byte[gi] = 8'h00;
      end
   end

   // Carrier runs from reset regardless of state or enable.
   assign car_tc = (car_ctr_q == CAR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_ctr_q <= '0;
         carrier_q <= 1'b0;
         ask_mod_q <= 1'b0;
      end else begin
         car_ctr_q <= car_tc ? '0 : car_ctr_q + CAR_ONE;
         carrier_q <= car_tc ? ~carrier_q : carrier_q;
         ask_mod_q <= carrier_q & message_q;
      end
   end

   // Search upward from the slot after the last grant, wrapping at N_REQ.
   always_comb begin
      valid_ext              = '0;
      valid_ext[N_REQ-1:0]   = req_valid;
      grant_found            = 1'b0;
      grant_idx              = ptr_q;
      search_idx             = ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         search_idx = (search_idx == REQ_LAST) ? 2'd0 : search_idx + 2'd1;
         if (!grant_found && valid_ext[search_idx]) begin
            grant_found = 1'b1;
            grant_idx   = search_idx;
         end
      end
   end

   assign grant_go = (state_q == S_IDLE) && enable && grant_found;
   assign bit_tick = (bit_ctr_q == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_go)                           state_d = S_PRE;
         S_PRE:   if (bit_tick && bit_idx_q == PRE_LAST)  state_d = S_DATA;
         S_DATA:  if (bit_tick && bit_idx_q == DATA_LAST) state_d = S_GUARD;
         S_GUARD: if (bit_tick && bit_idx_q == GRD_LAST)  state_d = S_IDLE;
         default:                                         state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bit_ctr_d  = bit_ctr_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      message_d  = message_q;
      busy_d     = busy_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      if (state_q == S_IDLE) begin
         bit_ctr_d = '0;
         bit_idx_d = '0;
         if (grant_go) begin
            shift_d    = req_byte[grant_idx];
            grant_id_d = grant_idx;
            ptr_d      = grant_idx;
            message_d  = 1'b1;
            busy_d     = 1'b1;
         end
      end else begin
         bit_ctr_d = bit_tick ? '0 : bit_ctr_q + BIT_ONE;
         if (bit_tick) begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            case (state_q)
               S_PRE: begin
                  if (bit_idx_q == PRE_LAST) begin
                     bit_idx_d = '0;
                     message_d = shift_q[7];
                     shift_d   = {shift_q[6:0], 1'b0};
                  end else begin
                     message_d = ~message_q;
                  end
               end
               S_DATA: begin
                  if (bit_idx_q == DATA_LAST) begin
                     bit_idx_d = '0;
                     message_d = 1'b0;
                  end else begin
                     message_d = shift_q[7];
                     shift_d   = {shift_q[6:0], 1'b0};
                  end
               end
               S_GUARD: begin
                  message_d = 1'b0;
                  if (bit_idx_q == GRD_LAST) begin
                     bit_idx_d = '0;
                     busy_d    = 1'b0;
                  end
               end
               default: begin
                  bit_idx_d = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_ctr_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= 8'h00;
         message_q  <= 1'b0;
         busy_q     <= 1'b0;
         grant_id_q <= 2'd0;
         ptr_q      <= REQ_LAST;
      end else begin
         bit_ctr_q  <= bit_ctr_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         message_q  <= message_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   // The ready pulse is combinational so the byte transfers on the grant edge;
   // it is held low while reset is asserted.
   always_comb begin
      ready_ext = '0;
      if (grant_go && rst_n) ready_ext[grant_idx] = 1'b1;
   end

   assign req_ready = ready_ext[N_REQ-1:0];
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;
   assign carrier   = carrier_q;
   assign message   = message_q;
   assign ask_mod   = ask_mod_q;

endmodule

// File: tb/tb_ask_tx_scheduler.sv
// Self-checking bench for ask_tx_scheduler: frame bit sequences, round-robin order,
// enable gating, input isolation after grant and asynchronous reset.
module tb_ask_tx_scheduler;
   localparam int CAR_DIV    = 2;
   localparam int BIT_DIV    = 8;
   localparam int N_REQ      = 4;
   localparam int PRE_BITS   = 4;
   localparam int GUARD_BITS = 2;
   localparam int FRAME_BITS = PRE_BITS + 8 + GUARD_BITS;
   localparam int FRAME_CYC  = FRAME_BITS * BIT_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  req_valid = 4'h0;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  req_ready;
   logic        busy;
   logic [1:0]  grant_id;
   logic        carrier;
   logic        message;
   logic        ask_mod;

   int checks = 0;
   int errors = 0;
   int rr_last = N_REQ - 1;
   int ncyc;
   logic prev_car, prev_msg;

   ask_tx_scheduler #(
      .CAR_DIV(CAR_DIV), .BIT_DIV(BIT_DIV), .N_REQ(N_REQ),
      .PRE_BITS(PRE_BITS), .GUARD_BITS(GUARD_BITS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .busy(busy), .grant_id(grant_id), .carrier(carrier),
      .message(message), .ask_mod(ask_mod)
   );

   always #5 clk = ~clk;

   // Clock edges seen since reset release; the carrier is a pure function of it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   function automatic logic exp_car();
      return ((ncyc / CAR_DIV) % 2) == 1;
   endfunction

   function automatic int rr_pick(input logic [3:0] mask);
      for (int k = 1; k <= N_REQ; k++) begin
         int j;
         j = (rr_last + k) % N_REQ;
         if (mask[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] v, input int g);
      logic [31:0] s;
      s = v >> (8 * g);
      return s[7:0];
   endfunction

   // Called inside (or before) the grant cycle; checks the full frame cycle by cycle.
   task automatic check_frame(input int g, input logic [7:0] d, input bit drop_valid,
                              input bit chg_data, input int en_off_at, input int stop_at,
                              output int waited);
      logic exp_bits [FRAME_BITS];
      logic [3:0] exp_rdy;
      for (int k = 0; k < FRAME_BITS; k++) begin
         if (k < PRE_BITS)          exp_bits[k] = ((k % 2) == 0);
         else if (k < PRE_BITS + 8) exp_bits[k] = d[7 - (k - PRE_BITS)];
         else                       exp_bits[k] = 1'b0;
      end
      exp_rdy = 4'(1 << g);
      #1;
      waited = 0;
      while (req_ready === 4'h0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL grant_ready got %b want %b", req_ready, exp_rdy);
         return;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL grant_busy got %b want 0", busy);
      end
      rr_last  = g;
      prev_car = carrier;
      prev_msg = message;
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy cyc %0d got %b want 1", c, busy);
         end
         checks++;
         if (message !== exp_bits[c / BIT_DIV]) begin
            errors++;
            $display("FAIL message cyc %0d got %b want %b", c, message, exp_bits[c / BIT_DIV]);
         end
         checks++;
         if (grant_id !== 2'(g)) begin
            errors++;
            $display("FAIL grant_id cyc %0d got %0d want %0d", c, grant_id, g);
         end
         checks++;
         if (req_ready !== 4'h0) begin
            errors++;
            $display("FAIL ready_in_frame cyc %0d got %b want 0000", c, req_ready);
         end
         checks++;
         if (ask_mod !== (prev_car & prev_msg)) begin
            errors++;
            $display("FAIL ask_mod cyc %0d got %b want %b", c, ask_mod, prev_car & prev_msg);
         end
         checks++;
         if (carrier !== exp_car()) begin
            errors++;
            $display("FAIL carrier cyc %0d got %b want %b", c, carrier, exp_car());
         end
         prev_car = carrier;
         prev_msg = message;
         if (c == 0) begin
            if (drop_valid) req_valid[g] = 1'b0;
            if (chg_data) req_data = req_data | (32'hFF << (8 * g));
         end
         if (c == en_off_at) enable = 1'b0;
         if (c == stop_at) return;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if ({busy, message, ask_mod, carrier, grant_id, req_ready} !== 10'b0) begin
         errors++;
         $display("FAIL %s got busy=%b msg=%b ask=%b car=%b gid=%0d rdy=%b want all 0",
                  tag, busy, message, ask_mod, carrier, grant_id, req_ready);
      end
   endtask

   task automatic test_reset();
      #3;
      check_outputs_zero("reset_outputs");
      @(negedge clk);
      check_outputs_zero("reset_held");
      #2 rst_n = 1'b1;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         checks++;
         if (carrier !== exp_car()) begin
            errors++;
            $display("FAIL idle_carrier cyc %0d got %b want %b", c, carrier, exp_car());
         end
         checks++;
         if ({message, ask_mod, busy, req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL idle_quiet cyc %0d got msg=%b ask=%b busy=%b rdy=%b want 0",
                     c, message, ask_mod, busy, req_ready);
         end
      end
   endtask

   task automatic test_single();
      int w;
      enable    = 1'b1;
      req_data  = 32'h0000_00AC;
      req_valid = 4'b0001;
      check_frame(0, 8'hAC, 1'b1, 1'b0, -1, -1, w);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL single_after got busy=%b rdy=%b want 0", busy, req_ready);
         end
      end
   endtask

   task automatic test_random_arb();
      int w, g;
      logic [3:0] mask;
      for (int it = 0; it < 6; it++) begin
         mask      = 4'($urandom_range(1, 15));
         req_data  = $urandom;
         req_valid = mask;
         g = rr_pick(mask);
         check_frame(g, byte_of(req_data, g), 1'b0, 1'b0, -1, -1, w);
      end
      req_valid = 4'h0;
   endtask

   task automatic test_round_robin();
      int w, g;
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'h0;
      rr_last   = N_REQ - 1;
      @(negedge clk);
      #2 rst_n = 1'b1;
      req_data  = 32'h1312_1110;
      req_valid = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         g = rr_pick(req_valid);
         check_frame(g, byte_of(req_data, g), 1'b0, 1'b0, -1, -1, w);
         if (f > 0) begin
            checks++;
            if (w !== 1) begin
               errors++;
               $display("FAIL rr_gap frame %0d got %0d idle cycles want 1", f, w);
            end
         end
      end
      req_valid = 4'b0100;
   endtask

   task automatic test_enable_drop();
      int w, g;
      req_data = $urandom;
      g = rr_pick(req_valid);
      check_frame(g, byte_of(req_data, g), 1'b0, 1'b0, 30, -1, w);
      req_valid = 4'b1111;
      req_data  = $urandom;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL disabled_grant cyc %0d got busy=%b rdy=%b want 0", c, busy, req_ready);
         end
      end
      enable = 1'b1;
      g = rr_pick(req_valid);
      check_frame(g, byte_of(req_data, g), 1'b0, 1'b0, -1, -1, w);
      checks++;
      if (w !== 0) begin
         errors++;
         $display("FAIL reenable_latency got %0d want 0", w);
      end
      req_valid = 4'b0100;
   endtask

   task automatic test_data_hold();
      int w, g;
      logic [7:0] d;
      d = 8'($urandom_range(0, 254));
      req_data = {8'h00, d, 16'h0000};
      g = rr_pick(req_valid);
      check_frame(g, d, 1'b1, 1'b1, -1, -1, w);
   endtask

   task automatic test_reset_mid();
      int w, g;
      req_valid = 4'b0100;
      req_data  = $urandom;
      g = rr_pick(req_valid);
      check_frame(g, byte_of(req_data, g), 1'b0, 1'b0, -1, 50, w);
      #2 rst_n = 1'b0;
      req_valid = 4'b1111;
      #1;
      check_outputs_zero("reset_async");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_outputs_zero("reset_mid_held");
      end
      #2 rst_n = 1'b1;
      rr_last = N_REQ - 1;
      g = rr_pick(req_valid);
      check_frame(g, byte_of(req_data, g), 1'b1, 1'b0, -1, -1, w);
      checks++;
      if (w !== 0) begin
         errors++;
         $display("FAIL post_reset_latency got %0d want 0", w);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_random_arb();
      test_round_robin();
      test_enable_drop();
      test_data_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end
endmodule
